decode_bundle_stage: RTL and testbench

Parametrised superscalar decode stage between fetch and rename. Accepts a fetch bundle of `FETCH_WIDTH` aligned instructions per cycle, decodes every lane in parallel and registers the result. Complex instructions (AMOs) and illegal encodings cause the bundle to be split into issue groups across several cycles. Valid/ready handshakes are used on both sides, and a flush input is provided.

---
 rtl/decode_bundle_stage_pkg.sv | 66 ++++++
 rtl/decode_lane.sv | 109 ++++++++++
 rtl/decode_bundle_stage.sv | 121 ++++++++++++
 tb/tb_decode_bundle_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_bundle_stage_pkg.sv
// Shared decode types: raw/decoded instruction formats, per-lane decode result,
// RV64 opcode and AMO funct5 encodings.
package decode_bundle_stage_pkg;

    localparam int unsigned ILEN = 32;

    typedef logic [ILEN-1:0] aligned_instr_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_ALUI,
        OP_ALU,
        OP_AMO,
        OP_FENCE,
        OP_SYSTEM
    } op_class_e;

    typedef struct packed {
        aligned_instr_t raw;
        op_class_e      op;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [2:0]     funct3;
        logic [31:0]    imm;
    } decoded_instr_t;

    typedef struct packed {
        decoded_instr_t instr;
        logic           is_complex;
        logic           is_illegal;
    } decode_lane_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

endpackage

// File: rtl/decode_lane.sv
// Combinational single-lane decoder: fields, immediate, op class, and the
// illegal / complex (non-LR/SC AMO) classification.
module decode_lane
    import decode_bundle_stage_pkg::*;
(
    input  aligned_instr_t i_instr,
    output decode_lane_t   o_lane_c
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_f5;
    logic       w_f5_ok;
    logic       w_ill;
    logic       w_cx;
    op_class_e  w_op;
    logic [31:0] w_imm;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_f5  = i_instr[31:27];

    always_comb begin
        w_f5_ok = 1'b0;
        w_ill   = 1'b0;
        w_cx    = 1'b0;
        w_op    = OP_NONE;
        w_imm   = '0;
        case (w_f5)
            AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND,
            AMO_OR, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: w_f5_ok = 1'b1;
            default: w_f5_ok = 1'b0;
        endcase
        case (w_opc)
            OPC_LUI: begin
                w_op  = OP_LUI;
                w_imm = {i_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_op  = OP_AUIPC;
                w_imm = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_op  = OP_JAL;
                w_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_op  = OP_JALR;
                w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
                w_ill = (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_op  = OP_BRANCH;
                w_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                w_ill = (w_f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                w_op  = OP_LOAD;
                w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
                w_ill = (w_f3 == 3'd7);
            end
            OPC_STORE: begin
                w_op  = OP_STORE;
                w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_ill = w_f3[2];
            end
            OPC_OP_IMM: begin
                w_op  = OP_ALUI;
                w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
                // RV64 shifts carry a 6-bit shamt, so only funct7[6:1] is checked
                w_ill = ((w_f3 == 3'd1) && (w_f7[6:1] != 6'd0)) ||
                        ((w_f3 == 3'd5) && (w_f7[6:1] != 6'd0) && (w_f7[6:1] != 6'b010000));
            end
            OPC_OP: begin
                w_op  = OP_ALU;
                w_ill = !((w_f7 == 7'd0) || (w_f7 == 7'd1) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
            end
            OPC_AMO: begin
                w_op  = OP_AMO;
                w_ill = (w_f3[2:1] != 2'b01) || !w_f5_ok ||
                        ((w_f5 == AMO_LR) && (i_instr[24:20] != 5'd0));
                w_cx  = !w_ill && (w_f5 != AMO_LR) && (w_f5 != AMO_SC);
            end
            OPC_FENCE: begin
                w_op  = OP_FENCE;
                w_ill = (w_f3[2:1] != 2'b00);
            end
            OPC_SYSTEM: w_op = OP_SYSTEM;
            default:    w_ill = 1'b1;
        endcase
    end

    always_comb begin
        o_lane_c                  = '0;
        o_lane_c.instr.raw        = i_instr;
        o_lane_c.instr.op         = w_op;
        o_lane_c.instr.rd         = i_instr[11:7];
        o_lane_c.instr.rs1        = i_instr[19:15];
        o_lane_c.instr.rs2        = i_instr[24:20];
        o_lane_c.instr.funct3     = w_f3;
        o_lane_c.instr.imm        = w_imm;
        o_lane_c.is_complex       = w_cx;
        o_lane_c.is_illegal       = w_ill;
    end

endmodule

// File: rtl/decode_bundle_stage.sv
// Superscalar decode stage: decodes a fetch bundle per cycle and splits it into
// issue groups around complex (AMO) and illegal lanes.
module decode_bundle_stage
    import decode_bundle_stage_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned PC_WIDTH    = 64
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_flush,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [PC_WIDTH-1:0]                    i_pc,
    input  aligned_instr_t [FETCH_WIDTH-1:0]       i_instr,
    input  logic [FETCH_WIDTH-1:0]                 i_slot_valid,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [PC_WIDTH-1:0]                    o_pc,
    output decoded_instr_t [FETCH_WIDTH-1:0]       o_instr,
    output logic [FETCH_WIDTH-1:0]                 o_slot_valid,
    output logic [FETCH_WIDTH-1:0]                 o_illegal,
    output logic [FETCH_WIDTH-1:0]                 o_complex
);

    localparam int unsigned PTR_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    decode_lane_t [FETCH_WIDTH-1:0]   w_lane;
    logic [FETCH_WIDTH-1:0]           w_grp;
    logic [FETCH_WIDTH-1:0]           w_grp_ill;
    logic [FETCH_WIDTH-1:0]           w_grp_cx;
    decoded_instr_t [FETCH_WIDTH-1:0] w_grp_instr;
    logic                             w_any;
    logic                             w_stop;
    logic                             w_ill_end;
    logic                             w_more;
    logic                             w_split;
    logic                             w_adv;
    int                               w_last;
    logic [PTR_W-1:0]                 r_ptr;
    logic [PTR_W-1:0]                 w_ptr_nxt;

    for (genvar g = 0; g < int'(FETCH_WIDTH); g++) begin : g_lane
        decode_lane u_decode_lane (
            .i_instr  (i_instr[g]),
            .o_lane_c (w_lane[g])
        );
    end

    // Priority scan from ptr: form one issue group and find where the next begins
    always_comb begin
        w_grp       = '0;
        w_grp_ill   = '0;
        w_grp_cx    = '0;
        w_grp_instr = '0;
        w_any       = 1'b0;
        w_stop      = 1'b0;
        w_ill_end   = 1'b0;
        w_more      = 1'b0;
        w_last      = 0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (!w_stop && (i >= int'(r_ptr)) && i_slot_valid[i]) begin
                if (w_lane[i].is_complex && w_any) begin
                    w_stop = 1'b1;
                end else begin
                    w_grp[i]       = 1'b1;
                    w_grp_ill[i]   = w_lane[i].is_illegal;
                    w_grp_cx[i]    = w_lane[i].is_complex;
                    w_grp_instr[i] = w_lane[i].instr;
                    w_last         = i;
                    w_any          = 1'b1;
                    if (w_lane[i].is_illegal) begin
                        w_stop    = 1'b1;
                        w_ill_end = 1'b1;
                    end else if (w_lane[i].is_complex) begin
                        w_stop = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if ((i > w_last) && i_slot_valid[i]) begin
                w_more = 1'b1;
            end
        end
        w_split   = w_any && w_more && !w_ill_end;
        w_ptr_nxt = PTR_W'(w_last + 1);
    end

    assign w_adv   = i_valid & (~o_valid | i_ready);
    assign o_ready = ~i_rst & (i_flush | (w_adv & ~w_split));

    // ptr plus the output register; ptr==0 is the first group of a bundle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= '0;
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_instr      <= '0;
            o_slot_valid <= '0;
            o_illegal    <= '0;
            o_complex    <= '0;
        end else if (i_flush) begin
            r_ptr   <= '0;
            o_valid <= 1'b0;
        end else if (w_adv) begin
            r_ptr   <= w_split ? w_ptr_nxt : '0;
            o_valid <= w_any;
            if (w_any) begin
                o_pc         <= i_pc;
                o_instr      <= w_grp_instr;
                o_slot_valid <= w_grp;
                o_illegal    <= w_grp_ill;
                o_complex    <= w_grp_cx;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_bundle_stage.sv
// Bench for decode_bundle_stage: directed scenarios plus random bundles checked
// against a group-list reference model.
module tb_decode_bundle_stage;
    import decode_bundle_stage_pkg::*;

    localparam int FW = 4;

    logic                    clk;
    logic                    i_rst;
    logic                    i_flush;
    logic                    i_valid;
    logic                    o_ready;
    logic [63:0]             i_pc;
    aligned_instr_t [FW-1:0] i_instr;
    logic [FW-1:0]           i_slot_valid;
    logic                    o_valid;
    logic                    i_ready;
    logic [63:0]             o_pc;
    decoded_instr_t [FW-1:0] o_instr;
    logic [FW-1:0]           o_slot_valid;
    logic [FW-1:0]           o_illegal;
    logic [FW-1:0]           o_complex;

    decode_bundle_stage #(.FETCH_WIDTH(FW), .PC_WIDTH(64)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_pc         (i_pc),
        .i_instr      (i_instr),
        .i_slot_valid (i_slot_valid),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pc         (o_pc),
        .o_instr      (o_instr),
        .o_slot_valid (o_slot_valid),
        .o_illegal    (o_illegal),
        .o_complex    (o_complex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam aligned_instr_t ADDI   = 32'h0010_0093;
    localparam aligned_instr_t AMOADD = 32'h0020_A02F;
    localparam aligned_instr_t BADOP  = 32'hFFFF_FFFF;

    aligned_instr_t legal_t[7]   = '{32'h0010_0093, 32'h0020_81B3, 32'h0000_A103,
                                     32'h0020_A023, 32'h1234_52B7, 32'h1000_A2AF, 32'h1820_A2AF};
    aligned_instr_t complex_t[3] = '{32'h0020_A02F, 32'h0820_A02F, 32'h4020_B02F};
    aligned_instr_t illegal_t[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFE20_81B3};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: all issue groups of the held bundle, in order
    typedef struct packed {
        logic [FW-1:0] m;
        logic [FW-1:0] il;
        logic [FW-1:0] cx;
    } grp_t;

    grp_t gq[$];
    int   cur_cat[FW];

    function automatic void build_groups(input logic [FW-1:0] mask);
        grp_t g;
        int   i;
        logic done;
        gq.delete();
        i    = 0;
        done = 1'b0;
        while (i < FW && !done) begin
            while (i < FW && !mask[i]) i++;
            if (i < FW) begin
                g = '0;
                if (cur_cat[i] == 1) begin
                    g.m[i]  = 1'b1;
                    g.cx[i] = 1'b1;
                    i++;
                end else begin
                    while (i < FW && !done) begin
                        if (!mask[i]) begin
                            i++;
                        end else if (cur_cat[i] == 1) begin
                            break;
                        end else begin
                            g.m[i] = 1'b1;
                            if (cur_cat[i] == 2) begin
                                g.il[i] = 1'b1;
                                done    = 1'b1;
                            end
                            i++;
                        end
                    end
                end
                gq.push_back(g);
            end
        end
    endfunction

    decoded_instr_t e_addi, e_amo;
    logic           e_ov;
    grp_t           e_g;
    logic [63:0]    e_pc;
    aligned_instr_t e_raw[FW];
    logic           held, fl, rdy, adv, e_rdy;
    int             r;

    initial begin
        e_addi = '0; e_addi.raw = ADDI; e_addi.op = OP_ALUI; e_addi.rd = 5'd1;
        e_addi.rs2 = 5'd1; e_addi.imm = 32'd1;
        e_amo = '0; e_amo.raw = AMOADD; e_amo.op = OP_AMO; e_amo.rs1 = 5'd1;
        e_amo.rs2 = 5'd2; e_amo.funct3 = 3'd2;

        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        i_pc = 64'h1000; i_instr = {4{ADDI}}; i_slot_valid = 4'hF;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ordy", 128'(o_ready), 128'(0));
        chk("rst_ov", 128'(o_valid), 128'(0));
        chk("rst_sv", 128'(o_slot_valid), 128'(0));

        // four ADDI, one group
        @(negedge clk); i_rst = 1'b0; #1;
        chk("t1_ordy", 128'(o_ready), 128'(1));
        step();
        chk("t1_ov", 128'(o_valid), 128'(1));
        chk("t1_sv", 128'(o_slot_valid), 128'(4'hF));
        chk("t1_ill", 128'(o_illegal), 128'(0));
        chk("t1_pc", 128'(o_pc), 128'(64'h1000));
        chk("t1_dec", 128'(o_instr[0]), 128'(e_addi));
        i_valid = 1'b0; step();

        // AMO in lane 2: three groups
        i_instr = {ADDI, AMOADD, ADDI, ADDI}; i_pc = 64'h2000; i_valid = 1'b1; #1;
        chk("t2_ordy0", 128'(o_ready), 128'(0));
        step();
        chk("t2_sv0", 128'(o_slot_valid), 128'(4'b0011));
        chk("t2_cx0", 128'(o_complex), 128'(0)); #1;
        chk("t2_ordy1", 128'(o_ready), 128'(0));
        step();
        chk("t2_sv1", 128'(o_slot_valid), 128'(4'b0100));
        chk("t2_cx1", 128'(o_complex), 128'(4'b0100));
        chk("t2_dec", 128'(o_instr[2]), 128'(e_amo));
        chk("t2_zero", 128'(o_instr[0]), 128'(0)); #1;
        chk("t2_ordy2", 128'(o_ready), 128'(1));
        step();
        chk("t2_sv2", 128'(o_slot_valid), 128'(4'b1000));
        chk("t2_pc", 128'(o_pc), 128'(64'h2000));
        i_valid = 1'b0; step();

        // illegal lane 1 ends the bundle
        i_instr = {ADDI, ADDI, BADOP, ADDI}; i_valid = 1'b1; #1;
        chk("t3_ordy", 128'(o_ready), 128'(1));
        step();
        chk("t3_sv", 128'(o_slot_valid), 128'(4'b0011));
        chk("t3_ill", 128'(o_illegal), 128'(4'b0010));
        i_valid = 1'b0; step();
        chk("t3_drop", 128'(o_valid), 128'(0));

        // downstream stall holds the group
        i_instr = {ADDI, AMOADD, ADDI, ADDI}; i_valid = 1'b1;
        step();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_ordy", 128'(o_ready), 128'(0));
            step();
            chk("t4_hold_ov", 128'(o_valid), 128'(1));
            chk("t4_hold_sv", 128'(o_slot_valid), 128'(4'b0011));
        end
        i_ready = 1'b1; #1;
        chk("t4_ordy_r", 128'(o_ready), 128'(0));
        step();
        chk("t4_sv1", 128'(o_slot_valid), 128'(4'b0100));
        step();
        chk("t4_sv2", 128'(o_slot_valid), 128'(4'b1000));
        i_valid = 1'b0; step();

        // flush mid-split
        i_instr = {ADDI, AMOADD, ADDI, ADDI}; i_valid = 1'b1;
        step();
        chk("t5_sv0", 128'(o_slot_valid), 128'(4'b0011));
        i_flush = 1'b1; #1;
        chk("t5_ordy", 128'(o_ready), 128'(1));
        step();
        i_flush = 1'b0;
        chk("t5_ov", 128'(o_valid), 128'(0));
        i_instr = {4{ADDI}}; #1;
        chk("t5_ordy_new", 128'(o_ready), 128'(1));
        step();
        chk("t5_sv_new", 128'(o_slot_valid), 128'(4'hF));
        i_valid = 1'b0; step();

        // reset while mid-split with a valid output
        i_instr = {ADDI, AMOADD, ADDI, ADDI}; i_valid = 1'b1;
        step();
        chk("t6_ov_pre", 128'(o_valid), 128'(1));
        i_rst = 1'b1; #1;
        chk("t6_ordy", 128'(o_ready), 128'(0));
        step();
        chk("t6_ov", 128'(o_valid), 128'(0));
        chk("t6_sv", 128'(o_slot_valid), 128'(0));
        chk("t6_ill", 128'(o_illegal), 128'(0));
        chk("t6_cx", 128'(o_complex), 128'(0));
        chk("t6_pc", 128'(o_pc), 128'(0));
        chk("t6_instr", 128'(o_instr), 128'(0)); #1;
        chk("t6_ordy_h", 128'(o_ready), 128'(0));
        i_rst = 1'b0; i_valid = 1'b0;
        step();

        // random traffic against the group-list model
        e_ov = 1'b0; held = 1'b0; e_g = '0; e_pc = '0;
        for (int l = 0; l < FW; l++) e_raw[l] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("r_ov", 128'(o_valid), 128'(e_ov));
            if (e_ov) begin
                chk("r_sv", 128'(o_slot_valid), 128'(e_g.m));
                chk("r_ill", 128'(o_illegal), 128'(e_g.il));
                chk("r_cx", 128'(o_complex), 128'(e_g.cx));
                chk("r_pc", 128'(o_pc), 128'(e_pc));
                for (int l = 0; l < FW; l++) begin
                    chk("r_raw", 128'(o_instr[l].raw), 128'(e_raw[l]));
                    if (e_g.cx[l]) chk("r_op", 128'(o_instr[l].op), 128'(OP_AMO));
                end
            end
            fl  = ($urandom_range(19) == 0);
            rdy = ($urandom_range(3) != 0);
            if (!held && ($urandom_range(4) != 0)) begin
                for (int l = 0; l < FW; l++) begin
                    r = int'($urandom_range(99));
                    if (r < 70) begin
                        cur_cat[l] = 0; i_instr[l] = legal_t[$urandom_range(6)];
                    end else if (r < 85) begin
                        cur_cat[l] = 1; i_instr[l] = complex_t[$urandom_range(2)];
                    end else begin
                        cur_cat[l] = 2; i_instr[l] = illegal_t[$urandom_range(2)];
                    end
                end
                i_slot_valid = ($urandom_range(2) == 0) ? 4'hF : 4'($urandom);
                i_pc = {$urandom, $urandom};
                build_groups(i_slot_valid);
                held = 1'b1;
            end
            i_valid = held; i_flush = fl; i_ready = rdy;
            #1;
            adv   = held && (!e_ov || rdy);
            e_rdy = fl || (adv && (gq.size() <= 1));
            chk("r_ordy", 128'(o_ready), 128'(e_rdy));
            if (fl) begin
                e_ov = 1'b0; held = 1'b0; gq.delete();
            end else if (adv) begin
                if (gq.size() == 0) begin
                    e_ov = 1'b0;
                end else begin
                    e_g  = gq.pop_front();
                    e_ov = 1'b1;
                    e_pc = i_pc;
                    for (int l = 0; l < FW; l++) e_raw[l] = e_g.m[l] ? i_instr[l] : '0;
                end
                if (gq.size() == 0) held = 1'b0;
            end else if (e_ov && rdy) begin
                e_ov = 1'b0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
